// File: rtl/memoria_dados_param.sv
// Parametrised synchronous data memory with registered reads and a post-reset zeroing sweep.
// Optional per-byte write mask enabled by defining MEMORIA_BYTE_MASK_EN.
module memoria_dados_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writeEnable,
  input  logic              readEnable,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dadoEntrada,
`ifdef MEMORIA_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] mascaraByte,
`endif
  output logic [DATA_W-1:0] dadoSaida,
  output logic              dadoValido,
  output logic              ocupado
);

  typedef enum logic {
    LIMPANDO,
    PRONTO
  } state_t;

  state_t state, state_nx;

  // One extra bit so DEPTH = 2**ADDR_W is reachable.
  logic [ADDR_W:0]   contador, contador_nx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              ready;
  logic              wr_en;
  logic              rd_en;
  logic              sweep_last;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] wr_data;

  assign ready      = (state == PRONTO);
  assign in_range   = (32'(endereco) < DEPTH);
  assign sweep_last = (32'(contador) == DEPTH - 1);
  assign wr_en      = ready && writeEnable && in_range;
  assign rd_en      = ready && readEnable;
  assign cur        = in_range ? mem[endereco] : '0;

  always_comb begin
    wr_data = dadoEntrada;
`ifdef MEMORIA_BYTE_MASK_EN
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      wr_data[8*i +: 8] = mascaraByte[i] ? dadoEntrada[8*i +: 8]
                                         : cur[8*i +: 8];
    end
`endif
  end

  always_comb begin
    state_nx    = state;
    contador_nx = contador;
    ocupado     = 1'b0;
    unique case (state)
      LIMPANDO: begin
        ocupado     = 1'b1;
        contador_nx = contador + 1'b1;
        if (sweep_last) state_nx = PRONTO;
      end
      PRONTO: begin
        state_nx = PRONTO;
      end
      default: begin
        state_nx = LIMPANDO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LIMPANDO;
      contador <= '0;
    end else begin
      state    <= state_nx;
      contador <= contador_nx;
    end
  end

  // Storage has no reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == LIMPANDO) begin
      mem[contador[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      mem[endereco] <= wr_data;
    end
  end

  // Write-first: a colliding read sees the merged write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dadoSaida  <= '0;
      dadoValido <= 1'b0;
    end else begin
      dadoValido <= rd_en;
      if (rd_en) begin
        if (!in_range)  dadoSaida <= '0;
        else if (wr_en) dadoSaida <= wr_data;
        else            dadoSaida <= cur;
      end
    end
  end

endmodule

// File: doc/memoria_dados_param.md
# memoria_dados_param

Parametrised synchronous data memory: the next generation of the processor's 8-bit data memory, generalised in data width, address width and depth. Adds registered reads with a valid flag, write-first collision behaviour and a post-reset clearing sweep so every word reads zero after reset. Sits between the datapath's load/store unit and the register file write-back mux.

## Interface
Parameters:
- DATA_W, 8, data word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- writeEnable  input  1  write request, sampled on the rising edge.
- readEnable  input  1  read request, sampled on the rising edge.
- endereco  input  ADDR_W  word address.
- dadoEntrada  input  DATA_W  write data.
- mascaraByte  input  DATA_W/8  per-byte write enable; present only with MEMORIA_BYTE_MASK_EN.
- dadoSaida  output  DATA_W  registered read data.
- dadoValido  output  1  one-cycle pulse: dadoSaida updated by a read.
- ocupado  output  1  high while the clearing sweep runs; requests are ignored.

## Operation
- FSM has two states: LIMPANDO and PRONTO.
- While rst_n is low, the block is held in LIMPANDO with the sweep counter at 0, dadoSaida=0, dadoValido=0 and ocupado=1.
- LIMPANDO: each rising edge writes 0 to word [contador] and increments the counter.
  - On the edge that writes DEPTH-1, the FSM moves to PRONTO and ocupado falls.
  - writeEnable and readEnable are ignored in this state.
- PRONTO, write with writeEnable=1 and endereco < DEPTH: the word is updated on the edge (per-byte masked, see Configuration).
- PRONTO, read with readEnable=1:
  - dadoSaida is loaded with the addressed word on the edge.
  - dadoValido=1 for exactly the following cycle.
- Read and write to the same address on the same edge: write-first. dadoSaida returns the newly written value; with the mask enabled, it returns the merged value.
- Out-of-range address (endereco ≥ DEPTH):
  - Writes are dropped and no word changes.
  - Reads return 0 with dadoValido=1.
- dadoSaida holds its last value when no read occurs; it never shows X after reset.
- Reset asserted mid-sweep or mid-operation: the FSM immediately returns to LIMPANDO and the sweep restarts from word 0 after release.

## Timing
- Read latency is 1 cycle: request sampled at edge N, data and dadoValido valid after edge N and until edge N+1.
- Write takes effect at edge N. A read of the same address at edge N+1 returns the new data.
- Back-to-back reads on every edge give continuous dadoValido=1 with a new word each cycle.
- ocupado stays high for exactly DEPTH rising edges after rst_n deasserts. The first accepted request is at edge DEPTH+1.
- Counter width is ADDR_W+1 bits so DEPTH=2^ADDR_W does not wrap prematurely.

## Configuration
- MEMORIA_BYTE_MASK_EN defined:
  - The mascaraByte port exists.
  - Write byte lane i (bits 8i+7:8i) is updated only when mascaraByte[i]=1.
  - A write with an all-zero mask changes nothing.
- MEMORIA_BYTE_MASK_EN undefined:
  - The mascaraByte port is absent.
  - Every write updates the full word.

## Test plan
Bench parameters: DATA_W=16, ADDR_W=8, DEPTH=200; clk period 10.
- Reset release and sweep: ocupado=1 for 200 edges. A write of 16'hFFFF to address 5 during the sweep is ignored. After the sweep, a read of address 5 returns 16'h0000 with dadoValido=1.
- Write/readback: write 16'hF00F@15 and 16'h0FF0@240. Read 15 returns 16'hF00F one cycle later. Read 240 (out of range) returns 16'h0000 with dadoValido=1.
- Collision: memory holds 16'hAAAA@15; a simultaneous write of 16'h1234 and read of 15 gives dadoSaida=16'h1234.
- Byte mask (macro on): word 7=16'hAAAA; write 16'h5555 with mascaraByte=2'b01; read 7 returns 16'hAA55.
- Mid-sweep reset: pulse rst_n low at sweep edge 100. ocupado stays high for 200 further edges after release. A write of 16'hBEEF before the reset is not readable afterwards (word reads 16'h0000).
- Hold: after a read returning 16'h1234, three idle cycles show dadoValido=0 and dadoSaida stays 16'h1234.
